// File: rtl/controle_pkg.sv
// Shared types and encodings for the multicycle control unit of the RV64 subset datapath.
// Holds the state enum, the opcode/funct constants it decodes and the ALU operation codes it drives.
package controle_pkg;

  typedef enum logic [3:0] {
    RESET    = 4'd0,
    FETCH    = 4'd1,
    FETCH_WB = 4'd2,
    DECODE   = 4'd3,
    EXEC_R   = 4'd4,
    EXEC_I   = 4'd5,
    WB_ALU   = 4'd6,
    ADDR     = 4'd7,
    MEM_LD   = 4'd8,
    WB_LD    = 4'd9,
    MEM_ST   = 4'd10,
    BRANCH   = 4'd11,
    LUI      = 4'd12,
    HALT     = 4'd13
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_BNE   = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BREAK = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_SD  = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b110;

  // Only the exact supported encodings leave DECODE for real work; everything else halts.
  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    state_t nxt;
    nxt = HALT;
    case (op)
      OP_R: begin
        if ((f7 == F7_BASE && f3 == F3_ADD) || (f7 == F7_SUB && f3 == F3_ADD) ||
            (f7 == F7_BASE && f3 == F3_AND))
          nxt = EXEC_R;
      end
      OP_ADDI: if (f3 == F3_ADD) nxt = EXEC_I;
      OP_LD:   if (f3 == F3_LD) nxt = ADDR;
      OP_SD:   if (f3 == F3_SD) nxt = ADDR;
      OP_BEQ:  if (f3 == F3_BEQ) nxt = BRANCH;
      OP_BNE:  if (f3 == F3_BNE) nxt = BRANCH;
      OP_LUI:  nxt = LUI;
      default: nxt = HALT;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] r_alu_op(input logic [2:0] f3, input logic [6:0] f7);
    logic [2:0] op;
    op = ALU_ADD;
    if (f7 == F7_SUB) op = ALU_SUB;
    else if (f3 == F3_AND) op = ALU_AND;
    return op;
  endfunction

endpackage

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM driving every enable and mux select of the UP datapath.
// Moore outputs decoded from state, except PCwrite in BRANCH which follows the zero flag.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i6_0,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  output logic       PCwrite,
  output logic       IRwrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AluOutWrite,
  output logic       MDRwrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluOperation,
  output logic [1:0] MemToReg,
  output logic       PCSource,
  output logic       exitState,
  output logic [3:0] state_out
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state;
  state_t     next_state;
  logic [2:0] wait_cnt;
  logic       wait_done;
  logic       counting;

  assign wait_done = (wait_cnt == WAIT_LAST);
  assign counting  = (state == FETCH) || (state == MEM_LD);
  assign state_out = state;

  // The wait counter only advances while a memory state is held, so each visit starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state || !counting) wait_cnt <= '0;
      else wait_cnt <= wait_cnt + 3'd1;
    end
  end

  always_comb begin
    next_state   = state;
    PCwrite      = 1'b0;
    IRwrite      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    AluOutWrite  = 1'b0;
    MDRwrite     = 1'b0;
    AluSrcA      = 1'b0;
    AluSrcB      = 2'b00;
    AluOperation = ALU_PASSA;
    MemToReg     = 2'b00;
    PCSource     = 1'b0;
    exitState    = 1'b0;
    case (state)
      RESET: next_state = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        if (wait_done) next_state = FETCH_WB;
      end
      FETCH_WB: begin
        IRwrite      = 1'b1;
        PCwrite      = 1'b1;
        AluSrcB      = 2'b01;
        AluOperation = ALU_ADD;
        next_state   = DECODE;
      end
      // Branch target is precomputed here so BRANCH can load PC from ALUOut.
      DECODE: begin
        AluSrcB      = 2'b11;
        AluOperation = ALU_ADD;
        AluOutWrite  = 1'b1;
        next_state   = decode_next(i6_0, funct3, funct7);
      end
      EXEC_R: begin
        AluSrcA      = 1'b1;
        AluOperation = r_alu_op(funct3, funct7);
        AluOutWrite  = 1'b1;
        next_state   = WB_ALU;
      end
      EXEC_I: begin
        AluSrcA      = 1'b1;
        AluSrcB      = 2'b10;
        AluOperation = ALU_ADD;
        AluOutWrite  = 1'b1;
        next_state   = WB_ALU;
      end
      WB_ALU: begin
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      ADDR: begin
        AluSrcA      = 1'b1;
        AluSrcB      = 2'b10;
        AluOperation = ALU_ADD;
        AluOutWrite  = 1'b1;
        next_state   = (i6_0 == OP_SD) ? MEM_ST : MEM_LD;
      end
      MEM_LD: begin
        MemRead = 1'b1;
        if (wait_done) begin
          MDRwrite   = 1'b1;
          next_state = WB_LD;
        end
      end
      WB_LD: begin
        RegWrite   = 1'b1;
        MemToReg   = 2'b01;
        next_state = FETCH;
      end
      MEM_ST: begin
        MemWrite   = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        AluSrcA      = 1'b1;
        AluOperation = ALU_SUB;
        PCSource     = 1'b1;
        PCwrite      = (i6_0 == OP_BNE) ? ~zero : zero;
        next_state   = FETCH;
      end
      LUI: begin
        RegWrite   = 1'b1;
        MemToReg   = 2'b10;
        next_state = FETCH;
      end
      HALT: exitState = 1'b1;
      default: next_state = RESET;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: a per-instruction cycle plan is queued as stimulus is
// issued, and a monitor compares every cycle of the selected instance against it.
module tb_controle_multiciclo;
  import controle_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mr, mw, rw, aow, mdrw, srca;
    logic [1:0] srcb;
    logic [2:0] op;
    logic [1:0] m2r;
    logic       pcs, ext;
  } obs_t;

  typedef struct {
    bit   inst;
    obs_t exp;
  } entry_t;

  typedef enum {K_ADD, K_SUB, K_AND, K_ADDI, K_LD, K_SD, K_BEQ, K_BNE, K_LUI, K_HALT} kind_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] i6_0 = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero = 1'b0;

  logic       pcw_a, irw_a, mr_a, mw_a, rw_a, aow_a, mdrw_a, srca_a, pcs_a, ext_a;
  logic [1:0] srcb_a, m2r_a;
  logic [2:0] op_a;
  logic [3:0] st_a;
  logic       pcw_b, irw_b, mr_b, mw_b, rw_b, aow_b, mdrw_b, srca_b, pcs_b, ext_b;
  logic [1:0] srcb_b, m2r_b;
  logic [2:0] op_b;
  logic [3:0] st_b;
  obs_t       act_a, act_b;

  entry_t sb[$];
  obs_t   plan[$];
  int     vectors = 0;
  int     miscompares = 0;
  bit     cur_inst = 1'b1;
  int     cur_w = 1;

  always #5 clk = ~clk;

  controle_multiciclo #(.MEM_WAIT(1)) dut (
    .clk(clk), .rst(rst), .i6_0(i6_0), .funct3(funct3), .funct7(funct7), .zero(zero),
    .PCwrite(pcw_a), .IRwrite(irw_a), .MemRead(mr_a), .MemWrite(mw_a), .RegWrite(rw_a),
    .AluOutWrite(aow_a), .MDRwrite(mdrw_a), .AluSrcA(srca_a), .AluSrcB(srcb_a),
    .AluOperation(op_a), .MemToReg(m2r_a), .PCSource(pcs_a), .exitState(ext_a),
    .state_out(st_a)
  );

  controle_multiciclo #(.MEM_WAIT(0)) dut_w0 (
    .clk(clk), .rst(rst), .i6_0(i6_0), .funct3(funct3), .funct7(funct7), .zero(zero),
    .PCwrite(pcw_b), .IRwrite(irw_b), .MemRead(mr_b), .MemWrite(mw_b), .RegWrite(rw_b),
    .AluOutWrite(aow_b), .MDRwrite(mdrw_b), .AluSrcA(srca_b), .AluSrcB(srcb_b),
    .AluOperation(op_b), .MemToReg(m2r_b), .PCSource(pcs_b), .exitState(ext_b),
    .state_out(st_b)
  );

  assign act_a = {st_a, pcw_a, irw_a, mr_a, mw_a, rw_a, aow_a, mdrw_a, srca_a,
                  srcb_a, op_a, m2r_a, pcs_a, ext_a};
  assign act_b = {st_b, pcw_b, irw_b, mr_b, mw_b, rw_b, aow_b, mdrw_b, srca_b,
                  srcb_b, op_b, m2r_b, pcs_b, ext_b};

  // Instruction classes straight from the ISA subset table; anything unlisted halts.
  function automatic kind_t classify(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7);
    kind_t k;
    k = K_HALT;
    case (op)
      7'b0110011: begin
        if (f7 == 7'b0000000 && f3 == 3'b000) k = K_ADD;
        else if (f7 == 7'b0100000 && f3 == 3'b000) k = K_SUB;
        else if (f7 == 7'b0000000 && f3 == 3'b111) k = K_AND;
      end
      7'b0010011: if (f3 == 3'b000) k = K_ADDI;
      7'b0000011: if (f3 == 3'b011) k = K_LD;
      7'b0100011: if (f3 == 3'b111) k = K_SD;
      7'b1100011: if (f3 == 3'b000) k = K_BEQ;
      7'b1100111: if (f3 == 3'b001) k = K_BNE;
      7'b0110111: k = K_LUI;
      default:    k = K_HALT;
    endcase
    return k;
  endfunction

  function automatic obs_t mk(input state_t s);
    obs_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  // Expected cycle-by-cycle behaviour of one whole instruction for a given memory wait.
  task automatic build_plan(input kind_t k, input bit z, input int w);
    obs_t e;
    plan.delete();
    e = mk(FETCH); e.mr = 1;
    for (int i = 0; i <= w; i++) plan.push_back(e);
    e = mk(FETCH_WB); e.irw = 1; e.pcw = 1; e.srcb = 2'b01; e.op = 3'b001;
    plan.push_back(e);
    e = mk(DECODE); e.srcb = 2'b11; e.op = 3'b001; e.aow = 1;
    plan.push_back(e);
    case (k)
      K_ADD, K_SUB, K_AND, K_ADDI: begin
        e = mk(k == K_ADDI ? EXEC_I : EXEC_R); e.srca = 1; e.aow = 1;
        e.srcb = (k == K_ADDI) ? 2'b10 : 2'b00;
        e.op = (k == K_SUB) ? 3'b010 : (k == K_AND) ? 3'b011 : 3'b001;
        plan.push_back(e);
        e = mk(WB_ALU); e.rw = 1;
        plan.push_back(e);
      end
      K_LD, K_SD: begin
        e = mk(ADDR); e.srca = 1; e.srcb = 2'b10; e.op = 3'b001; e.aow = 1;
        plan.push_back(e);
        if (k == K_LD) begin
          for (int i = 0; i <= w; i++) begin
            e = mk(MEM_LD); e.mr = 1; e.mdrw = (i == w);
            plan.push_back(e);
          end
          e = mk(WB_LD); e.rw = 1; e.m2r = 2'b01;
          plan.push_back(e);
        end else begin
          e = mk(MEM_ST); e.mw = 1;
          plan.push_back(e);
        end
      end
      K_BEQ, K_BNE: begin
        e = mk(BRANCH); e.srca = 1; e.op = 3'b010; e.pcs = 1;
        e.pcw = (k == K_BEQ) ? z : ~z;
        plan.push_back(e);
      end
      K_LUI: begin
        e = mk(LUI); e.rw = 1; e.m2r = 2'b10;
        plan.push_back(e);
      end
      default: begin
        e = mk(HALT); e.ext = 1;
        for (int i = 0; i < 10; i++) plan.push_back(e);
      end
    endcase
  endtask

  task automatic expect_cycle(input obs_t e);
    entry_t en;
    @(posedge clk);
    #1;
    en.inst = cur_inst;
    en.exp  = e;
    sb.push_back(en);
  endtask

  task automatic doReset();
    rst = 1'b1;
    expect_cycle(mk(RESET));
    expect_cycle(mk(RESET));
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input bit z, input state_t abort_at);
    kind_t k;
    k = classify(op, f3, f7);
    build_plan(k, z, cur_w);
    @(posedge clk);
    #1;
    i6_0 = op; funct3 = f3; funct7 = f7; zero = z;
    sb.push_back('{inst: cur_inst, exp: plan[0]});
    for (int i = 1; i < plan.size(); i++) begin
      if (plan[i-1].st == 4'(abort_at)) begin
        doReset();
        return;
      end
      expect_cycle(plan[i]);
    end
    if (plan[plan.size()-1].st == 4'(abort_at) || k == K_HALT) doReset();
  endtask

  task automatic random_instr();
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int sel;
    sel = $urandom_range(0, 11);
    op = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
    case (sel)
      0: begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000000; end
      1: begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
      2: begin op = 7'b0110011; f3 = 3'b111; f7 = 7'b0000000; end
      3: begin op = 7'b0010011; f3 = 3'b000; end
      4: begin op = 7'b0000011; f3 = 3'b011; end
      5: begin op = 7'b0100011; f3 = 3'b111; end
      6: begin op = 7'b1100011; f3 = 3'b000; end
      7: begin op = 7'b1100111; f3 = 3'b001; end
      8: op = 7'b0110111;
      9: op = 7'b1110011;
      10: op = op;
      default: op = 7'b0110011;
    endcase
    applyStimulus(op, f3, f7, 1'($urandom), RESET);
  endtask

  task automatic checkOutput(input entry_t en);
    obs_t act;
    act = en.inst ? act_a : act_b;
    vectors++;
    if (act !== en.exp) begin
      miscompares++;
      $display("[TB] FAIL cycle inst=%0d state=%0d: got %06h expected %06h",
               en.inst, en.exp.st, act, en.exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
    if (!$isunknown({mr_a, mw_a, rw_a, pcw_a}) && ((mr_a && mw_a) || (rw_a && pcw_a))) begin
      miscompares++;
      $display("[TB] FAIL invariant inst=1: MemRead=%b MemWrite=%b RegWrite=%b PCwrite=%b",
               mr_a, mw_a, rw_a, pcw_a);
    end
    if (!$isunknown({mr_b, mw_b, rw_b, pcw_b}) && ((mr_b && mw_b) || (rw_b && pcw_b))) begin
      miscompares++;
      $display("[TB] FAIL invariant inst=0: MemRead=%b MemWrite=%b RegWrite=%b PCwrite=%b",
               mr_b, mw_b, rw_b, pcw_b);
    end
  end

  initial begin
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    $display("[TB] directed sequence, MEM_WAIT=1");
    cur_inst = 1'b1; cur_w = 1;
    doReset();
    applyStimulus(7'b0110011, 3'b000, 7'b0000000, 1'b0, RESET);
    applyStimulus(7'b0000011, 3'b011, 7'b0010101, 1'b0, RESET);
    applyStimulus(7'b0100011, 3'b111, 7'b0000000, 1'b1, RESET);
    applyStimulus(7'b1100011, 3'b000, 7'b0000000, 1'b1, RESET);
    applyStimulus(7'b1100011, 3'b000, 7'b0000000, 1'b0, RESET);
    applyStimulus(7'b1100111, 3'b001, 7'b0000000, 1'b0, RESET);
    applyStimulus(7'b1100111, 3'b001, 7'b0000000, 1'b1, RESET);
    applyStimulus(7'b0010011, 3'b000, 7'b1111111, 1'b0, RESET);
    applyStimulus(7'b0110111, 3'b101, 7'b0110000, 1'b0, RESET);
    applyStimulus(7'b0110011, 3'b000, 7'b0100000, 1'b1, RESET);
    applyStimulus(7'b0110011, 3'b111, 7'b0000000, 1'b0, RESET);
    applyStimulus(7'b1110011, 3'b000, 7'b0000000, 1'b0, RESET);
    applyStimulus(7'b1111111, 3'b000, 7'b0000000, 1'b0, RESET);
    applyStimulus(7'b0100011, 3'b111, 7'b0000000, 1'b0, MEM_ST);
    applyStimulus(7'b0110011, 3'b000, 7'b0000000, 1'b0, EXEC_R);
    $display("[TB] random sequence, MEM_WAIT=1");
    for (int n = 0; n < 40; n++) random_instr();

    $display("[TB] sequence with MEM_WAIT=0");
    cur_inst = 1'b0; cur_w = 0;
    doReset();
    applyStimulus(7'b0000011, 3'b011, 7'b0000000, 1'b0, RESET);
    applyStimulus(7'b0100011, 3'b111, 7'b0000000, 1'b0, RESET);
    applyStimulus(7'b0110011, 3'b000, 7'b0000000, 1'b0, RESET);
    for (int n = 0; n < 15; n++) random_instr();

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
